// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I main controller: sequences FETCH/DECODE/EXEC/MEM/WB,
// handshakes with instruction and data memory, traps on illegal opcodes or
// memory timeouts, and counts retired instructions.
module multicycle_controller #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 32,
  parameter bit U_TYPE_EN      = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       Opcode,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic [1:0]       ALUSrcA,
  output logic             ALUSrc,
  output logic [1:0]       ALUOp,
  output logic [1:0]       MemtoReg,
  output logic             RegWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             Branch,
  output logic             Jump,
  output logic             Jalr,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  // The wait counter only ever needs to reach TIMEOUT_CYCLES-1: the cycle
  // that would bring it to the limit is the one that traps instead.
  localparam int          TW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TLIM = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t         state_q, state_d;
  logic [6:0]     op_q;
  logic [TW-1:0]  tcnt_q;
  logic [1:0]     cause_q, cause_d;
  logic           wait_rdy;
  logic           tmo_hit;
  logic [1:0]     alu_src_a_dec;
  logic           alu_src_dec;
  logic [1:0]     alu_op_dec;

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_R, OP_LW, OP_SW, OP_BR, OP_IMM, OP_JAL, OP_JALR: is_legal = 1'b1;
      OP_LUI, OP_AUIPC:                                  is_legal = U_TYPE_EN;
      default:                                           is_legal = 1'b0;
    endcase
  endfunction

  assign state      = state_q;
  assign trap_cause = cause_q;
  assign wait_rdy   = (state_q == S_FETCH) ? imem_ready : dmem_ready;
  assign tmo_hit    = (TIMEOUT_CYCLES > 0) && (tcnt_q == TLIM);

  // State, latched opcode, wait counter and trap cause registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      tcnt_q  <= '0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      if (state_q == S_DECODE) begin
        op_q <= Opcode;
      end
      // Cleared outside the wait states and on a ready, so every entry to
      // FETCH or MEM starts from zero.
      if ((state_q == S_FETCH) || (state_q == S_MEM)) begin
        if (wait_rdy) begin
          tcnt_q <= '0;
        end else if (TIMEOUT_CYCLES > 0) begin
          tcnt_q <= tcnt_q + 1'b1;
        end
      end else begin
        tcnt_q <= '0;
      end
    end
  end

  // Retired-instruction counter, one step per PC update, wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret <= '0;
    end else if (PCWrite) begin
      instret <= instret + 1'b1;
    end
  end

  // ALU operand/operation selection decoded from the latched opcode.
  always_comb begin
    alu_src_a_dec = 2'b00;
    alu_src_dec   = 1'b0;
    alu_op_dec    = 2'b00;
    case (op_q)
      OP_R:     alu_op_dec = 2'b10;
      OP_BR:    alu_op_dec = 2'b01;
      OP_IMM:   begin alu_op_dec = 2'b11; alu_src_dec = 1'b1; end
      OP_LW,
      OP_SW,
      OP_JALR:  alu_src_dec = 1'b1;
      OP_JAL:   alu_src_a_dec = 2'b01;
      OP_AUIPC: begin alu_src_a_dec = 2'b01; alu_src_dec = 1'b1; end
      OP_LUI:   begin alu_src_a_dec = 2'b10; alu_src_dec = 1'b1; end
      default:  ;
    endcase
  end

  // Next-state and control outputs; IRWrite and retire pulses are Mealy on ready.
  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    ALUSrcA  = 2'b00;
    ALUSrc   = 1'b0;
    ALUOp    = 2'b00;
    MemtoReg = 2'b00;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    Branch   = 1'b0;
    Jump     = 1'b0;
    Jalr     = 1'b0;
    trap     = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          IRWrite = 1'b1;
          state_d = S_DECODE;
        end else if (tmo_hit) begin
          state_d = S_TRAP;
          cause_d = 2'b10;
        end
      end
      S_DECODE: begin
        if (is_legal(Opcode)) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_TRAP;
          cause_d = 2'b01;
        end
      end
      S_EXEC: begin
        ALUSrcA = alu_src_a_dec;
        ALUSrc  = alu_src_dec;
        ALUOp   = alu_op_dec;
        if (op_q == OP_BR) begin
          Branch  = 1'b1;
          PCWrite = 1'b1;
          state_d = S_FETCH;
        end else if ((op_q == OP_LW) || (op_q == OP_SW)) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        ALUSrcA  = alu_src_a_dec;
        ALUSrc   = alu_src_dec;
        ALUOp    = alu_op_dec;
        MemRead  = (op_q == OP_LW);
        MemWrite = (op_q == OP_SW);
        if (dmem_ready) begin
          if (op_q == OP_SW) begin
            PCWrite = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (tmo_hit) begin
          state_d = S_TRAP;
          cause_d = 2'b11;
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
        if (op_q == OP_LW) begin
          MemtoReg = 2'b01;
        end else if ((op_q == OP_JAL) || (op_q == OP_JALR)) begin
          MemtoReg = 2'b10;
          Jump     = 1'b1;
        end
        Jalr    = (op_q == OP_JALR);
        state_d = S_FETCH;
      end
      S_TRAP:  trap = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: randomized instruction
// streams compared cycle by cycle against a transaction-level trace model.
module tb_multicycle_controller;

  localparam int TO = 4;
  localparam int CW = 4;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] LEGAL [9] = '{OP_R, OP_LW, OP_SW, OP_BR, OP_IMM,
                                       OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, imem_ready, dmem_ready;
  logic [6:0]    Opcode;
  logic          imem_req, dmem_req, IRWrite, PCWrite, ALUSrc;
  logic [1:0]    ALUSrcA, ALUOp, MemtoReg, trap_cause;
  logic          RegWrite, MemRead, MemWrite, Branch, Jump, Jalr, trap;
  logic [CW-1:0] instret;
  logic [2:0]    state;

  logic          rst_n_b, imem_ready_b, dmem_ready_b;
  logic [6:0]    opcode_b;
  logic          imem_req_b, dmem_req_b, ir_write_b, pc_write_b, alu_src_b;
  logic [1:0]    alu_src_a_b, alu_op_b, mem_to_reg_b, trap_cause_b;
  logic          reg_write_b, mem_read_b, mem_write_b, branch_b, jump_b, jalr_b, trap_b;
  logic [31:0]   instret_b;
  logic [2:0]    state_b;

  multicycle_controller #(.TIMEOUT_CYCLES(TO), .CNT_W(CW), .U_TYPE_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .imem_req(imem_req), .dmem_req(dmem_req),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .ALUSrcA(ALUSrcA), .ALUSrc(ALUSrc),
    .ALUOp(ALUOp), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .Branch(Branch), .Jump(Jump), .Jalr(Jalr), .trap(trap),
    .trap_cause(trap_cause), .instret(instret), .state(state)
  );

  multicycle_controller #(.TIMEOUT_CYCLES(0), .CNT_W(32), .U_TYPE_EN(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .Opcode(opcode_b), .imem_ready(imem_ready_b),
    .dmem_ready(dmem_ready_b), .imem_req(imem_req_b), .dmem_req(dmem_req_b),
    .IRWrite(ir_write_b), .PCWrite(pc_write_b), .ALUSrcA(alu_src_a_b), .ALUSrc(alu_src_b),
    .ALUOp(alu_op_b), .MemtoReg(mem_to_reg_b), .RegWrite(reg_write_b), .MemRead(mem_read_b),
    .MemWrite(mem_write_b), .Branch(branch_b), .Jump(jump_b), .Jalr(jalr_b), .trap(trap_b),
    .trap_cause(trap_cause_b), .instret(instret_b), .state(state_b)
  );

  typedef struct packed {
    logic       imem_req, dmem_req, ir_write, pc_write;
    logic [1:0] alu_src_a;
    logic       alu_src;
    logic [1:0] alu_op, mem_to_reg;
    logic       reg_write, mem_read, mem_write, branch, jump, jalr, trap;
    logic [1:0] cause;
    logic [2:0] st;
  } ctl_t;

  typedef struct packed {
    logic       legal;
    logic [1:0] srca;
    logic       src;
    logic [1:0] aluop;
    logic       is_ld, is_st, is_br, is_jal, is_jalr;
  } cls_t;

  int         n_chk = 0;
  int         n_err = 0;
  int         m_cnt = 0;
  logic [1:0] m_cause = 2'b00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic ctl_t observe();
    ctl_t o;
    o = '{imem_req, dmem_req, IRWrite, PCWrite, ALUSrcA, ALUSrc, ALUOp, MemtoReg,
          RegWrite, MemRead, MemWrite, Branch, Jump, Jalr, trap, trap_cause, state};
    return o;
  endfunction

  // Instruction-class table straight from the ISA-level control rules.
  function automatic cls_t classify(input logic [6:0] op);
    cls_t c;
    c = '0;
    c.legal = 1'b1;
    case (op)
      OP_R:     c.aluop = 2'b10;
      OP_LW:    begin c.src = 1'b1; c.is_ld = 1'b1; end
      OP_SW:    begin c.src = 1'b1; c.is_st = 1'b1; end
      OP_BR:    begin c.aluop = 2'b01; c.is_br = 1'b1; end
      OP_IMM:   begin c.src = 1'b1; c.aluop = 2'b11; end
      OP_JAL:   begin c.srca = 2'b01; c.is_jal = 1'b1; end
      OP_JALR:  begin c.src = 1'b1; c.is_jalr = 1'b1; end
      OP_LUI:   begin c.src = 1'b1; c.srca = 2'b10; end
      OP_AUIPC: begin c.src = 1'b1; c.srca = 2'b01; end
      default:  c.legal = 1'b0;
    endcase
    return c;
  endfunction

  task automatic cyc(input string tag, input logic [6:0] opc, input logic ir,
                     input logic dr, input ctl_t e);
    Opcode     = opc;
    imem_ready = ir;
    dmem_ready = dr;
    #1;
    chk(tag, 32'(observe()), 32'(e));
    chk({tag, "/instret"}, 32'(instret), 32'(m_cnt % (1 << CW)));
    if (e.pc_write) m_cnt++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    ctl_t z;
    z = '0;
    rst_n = 1'b0;
    #1;
    chk("reset", 32'(observe()), 32'(z));
    chk("reset/instret", 32'(instret), 32'd0);
    m_cnt   = 0;
    m_cause = 2'b00;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc("idle", 7'($urandom), 1'($urandom), 1'($urandom), z);
  endtask

  task automatic trap_hold(input int n);
    ctl_t e;
    for (int i = 0; i < n; i++) begin
      e = '0;
      e.trap  = 1'b1;
      e.cause = m_cause;
      e.st    = 3'd6;
      cyc("trap", 7'($urandom), 1'($urandom), 1'($urandom), e);
    end
  endtask

  // Drives one instruction through the controller while predicting every
  // cycle. iw/dw = ready-low cycles before the memory answers (>= TO never).
  task automatic run_instr(input logic [6:0] op, input int iw, input int dw,
                           input bit abort_mem, output bit trapped);
    cls_t c;
    ctl_t e;
    logic rdy;
    c = classify(op);
    trapped = 1'b0;
    for (int k = 0; k < TO; k++) begin
      rdy = (k == iw);
      e = '0;
      e.st = 3'd1; e.imem_req = 1'b1; e.ir_write = rdy;
      cyc("fetch", 7'($urandom), rdy, 1'($urandom), e);
      if (rdy) break;
      if (k + 1 == TO) begin m_cause = 2'b10; trapped = 1'b1; return; end
    end
    e = '0;
    e.st = 3'd2;
    cyc("decode", op, 1'($urandom), 1'($urandom), e);
    if (!c.legal) begin m_cause = 2'b01; trapped = 1'b1; return; end
    e = '0;
    e.st = 3'd3; e.alu_src_a = c.srca; e.alu_src = c.src; e.alu_op = c.aluop;
    e.branch = c.is_br; e.pc_write = c.is_br;
    cyc("exec", 7'($urandom), 1'($urandom), 1'($urandom), e);
    if (c.is_br) return;
    if (c.is_ld || c.is_st) begin
      for (int k = 0; k < TO; k++) begin
        rdy = (k == dw);
        e = '0;
        e.st = 3'd4; e.dmem_req = 1'b1;
        e.alu_src_a = c.srca; e.alu_src = c.src; e.alu_op = c.aluop;
        e.mem_read = c.is_ld; e.mem_write = c.is_st; e.pc_write = rdy && c.is_st;
        if (abort_mem) begin
          Opcode = 7'($urandom); imem_ready = 1'($urandom); dmem_ready = 1'b0;
          #1;
          chk("mem_pre_abort", 32'(observe()), 32'(e));
          rst_n = 1'b0;
          #1;
          e = '0;
          chk("abort", 32'(observe()), 32'(e));
          chk("abort/instret", 32'(instret), 32'd0);
          m_cnt = 0; m_cause = 2'b00;
          @(posedge clk);
          @(negedge clk);
          rst_n = 1'b1;
          cyc("idle_after_abort", 7'($urandom), 1'($urandom), 1'($urandom), e);
          return;
        end
        cyc("mem", 7'($urandom), 1'($urandom), rdy, e);
        if (rdy) break;
        if (k + 1 == TO) begin m_cause = 2'b11; trapped = 1'b1; return; end
      end
      if (c.is_st) return;
    end
    e = '0;
    e.st = 3'd5; e.reg_write = 1'b1; e.pc_write = 1'b1;
    e.mem_to_reg = c.is_ld ? 2'b01 : ((c.is_jal || c.is_jalr) ? 2'b10 : 2'b00);
    e.jump = c.is_jal || c.is_jalr; e.jalr = c.is_jalr;
    cyc("wb", 7'($urandom), 1'($urandom), 1'($urandom), e);
  endtask

  task automatic cyc_b(input string tag, input logic [6:0] opc, input logic ir,
                       input logic [7:0] exp);
    opcode_b     = opc;
    imem_ready_b = ir;
    dmem_ready_b = 1'b0;
    #1;
    chk(tag, {24'd0, trap_b, trap_cause_b, state_b, imem_req_b, ir_write_b}, {24'd0, exp});
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    n_err++;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk + 1);
    $fatal(1);
  end

  initial begin
    bit tr;
    rst_n = 1'b0; Opcode = '0; imem_ready = 1'b0; dmem_ready = 1'b0;
    rst_n_b = 1'b0; opcode_b = '0; imem_ready_b = 1'b0; dmem_ready_b = 1'b0;
    @(negedge clk);
    do_reset();

    // Directed instruction mix including ready-on-limit boundaries.
    run_instr(OP_R,     2, 0, 1'b0, tr);
    run_instr(OP_LW,    0, 1, 1'b0, tr);
    run_instr(OP_SW,    1, 0, 1'b0, tr);
    run_instr(OP_BR,    0, 0, 1'b0, tr);
    run_instr(OP_JALR,  0, 0, 1'b0, tr);
    run_instr(OP_LUI,   1, 0, 1'b0, tr);
    run_instr(OP_AUIPC, 0, 0, 1'b0, tr);
    run_instr(OP_JAL,   0, 0, 1'b0, tr);
    run_instr(OP_IMM,   TO - 1, 0, 1'b0, tr);
    run_instr(OP_LW,    0, TO - 1, 1'b0, tr);

    // Random legal stream; instret wraps several times at this width.
    for (int i = 0; i < 120; i++) begin
      run_instr(LEGAL[$urandom_range(0, 8)], $urandom_range(0, TO - 1),
                $urandom_range(0, TO - 1), 1'b0, tr);
    end

    // Illegal opcode: sticky cause until reset.
    run_instr(7'b1111111, 0, 0, 1'b0, tr);
    trap_hold(6);
    do_reset();

    // Reset in the middle of a load's memory phase.
    run_instr(OP_R,  0, 0, 1'b0, tr);
    run_instr(OP_LW, 1, 2, 1'b1, tr);
    run_instr(OP_SW, 0, 0, 1'b0, tr);

    // Instruction memory never answers.
    run_instr(OP_R, 99, 0, 1'b0, tr);
    trap_hold(4);
    do_reset();

    // Data memory never answers.
    run_instr(OP_LW, 0, 99, 1'b0, tr);
    trap_hold(4);
    do_reset();
    run_instr(OP_SW, 0, 0, 1'b0, tr);

    // Timeout disabled and U-type disabled instance.
    rst_n_b = 1'b1;
    cyc_b("b_idle", 7'($urandom), 1'b0, {1'b0, 2'b00, 3'd0, 1'b0, 1'b0});
    for (int i = 0; i < 100; i++) begin
      cyc_b("b_fetch_hold", 7'($urandom), 1'b0, {1'b0, 2'b00, 3'd1, 1'b1, 1'b0});
    end
    cyc_b("b_fetch_accept", 7'($urandom), 1'b1, {1'b0, 2'b00, 3'd1, 1'b1, 1'b1});
    cyc_b("b_decode_lui", OP_LUI, 1'b0, {1'b0, 2'b00, 3'd2, 1'b0, 1'b0});
    for (int i = 0; i < 3; i++) begin
      cyc_b("b_trap", 7'($urandom), 1'($urandom), {1'b1, 2'b01, 3'd6, 1'b0, 1'b0});
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
